fetch_unit: RTL and testbench

//  Instruction-fetch stage; feeds the decode stage.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, one-cycle-latency imem requests and a
// small {pc, instr} output FIFO with credit-based issue and redirect flush.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        valid_out,
   input  logic        ready_out,
   output logic [31:0] instr,
   output logic [31:0] pc_out
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc;
   logic [31:0]   inflight_pc;
   logic          inflight;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic          pop;
   logic          push;
   logic [CW:0]   credit;

   // Credit counts buffered plus in-flight words, minus the one leaving now,
   // so a request is only issued when its response is guaranteed a slot.
   always_comb begin
      valid_out = (count != '0);
      pop       = valid_out & ready_out;
      credit    = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
      imem_req  = reset & ~redirect_valid & (credit < (CW+1)'(FIFO_DEPTH));
      imem_addr = pc;
      push      = inflight & ~redirect_valid;
      instr     = valid_out ? fifo_instr[rd_ptr] : '0;
      pc_out    = valid_out ? fifo_pc[rd_ptr]    : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         inflight_pc <= '0;
         inflight    <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         // The flush empties the FIFO, so a same-cycle pop needs no bookkeeping.
         pc       <= {redirect_pc[31:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc          <= pc + 32'd4;
            inflight_pc <= pc;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the output mux hides stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= inflight_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of outstanding fetches.
module tb_fetch_unit;

   localparam logic [31:0] K        = 32'hA5A5_0000;
   localparam logic [31:0] RPC0     = 32'h0000_0000;
   localparam logic [31:0] RPC_WRAP = 32'hFFFF_FFF8;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        valid_out;
   logic        ready_out = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc_out;

   logic        d2_req;
   logic [31:0] d2_addr;
   logic [31:0] d2_rdata;
   logic        d2_redirect = 1'b0;
   logic [31:0] d2_redirect_pc = '0;
   logic        d2_valid;
   logic        d2_ready = 1'b1;
   logic [31:0] d2_instr;
   logic [31:0] d2_pc;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .valid_out(valid_out), .ready_out(ready_out), .instr(instr), .pc_out(pc_out));

   fetch_unit #(.RESET_PC(RPC_WRAP), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .reset(reset), .imem_req(d2_req), .imem_addr(d2_addr),
      .imem_rdata(d2_rdata), .redirect_valid(d2_redirect), .redirect_pc(d2_redirect_pc),
      .valid_out(d2_valid), .ready_out(d2_ready), .instr(d2_instr), .pc_out(d2_pc));

   // Synchronous instruction memories, one-cycle latency.
   always @(posedge clk) begin
      imem_rdata <= imem_addr ^ K;
      d2_rdata   <= d2_addr ^ K;
   end

   typedef struct {
      logic [31:0] pc;
      int          cyc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] pop_log[$];
   logic [31:0] log2[$];
   logic [31:0] mpc = RPC0;
   int          cyc = 0;
   bit          cap2 = 1'b0;
   int          vectors = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] lq[$], input int i);
      if (i < lq.size()) return lq[i];
      return 'x;
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, advance model.
   task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
      logic        ev, pop, er;
      logic [31:0] hpc;
      @(negedge clk);
      reset = rst; ready_out = rdy; redirect_valid = rv; redirect_pc = rpc;
      #1;
      if (!rst) begin
         q.delete();
         pop_log.delete();
         mpc = RPC0;
         chk("rst_valid", {31'b0, valid_out}, 32'd0);
         chk("rst_req",   {31'b0, imem_req},  32'd0);
         chk("rst_instr", instr,  32'd0);
         chk("rst_pc",    pc_out, 32'd0);
         chk("rst_addr",  imem_addr, RPC0);
      end else begin
         ev  = (q.size() > 0) && (cyc - q[0].cyc >= 2);
         hpc = ev ? q[0].pc : 32'd0;
         pop = ev && rdy;
         er  = !rv && ((q.size() - int'(pop)) < DEPTH);
         chk("valid_out", {31'b0, valid_out}, {31'b0, ev});
         chk("pc_out",    pc_out, hpc);
         chk("instr",     instr,  ev ? (hpc ^ K) : 32'd0);
         chk("imem_req",  {31'b0, imem_req}, {31'b0, er});
         chk("imem_addr", imem_addr, mpc);
         if (pop) begin
            pop_log.push_back(q[0].pc);
            void'(q.pop_front());
         end
         if (rv) begin
            q.delete();
            pop_log.delete();
            mpc = {rpc[31:2], 2'b00};
         end else if (er) begin
            q.push_back('{pc: mpc, cyc: cyc});
            mpc = mpc + 32'd4;
         end
      end
      if (cap2 && d2_valid) begin
         log2.push_back(d2_pc);
         chk("d2_instr", d2_instr, d2_pc ^ K);
      end
      cyc++;
   endtask

   initial begin
      // Reset state
      repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);

      // Stream from reset; second instance exercises the PC wrap
      cap2 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 7) cap2 = 1'b0;
         step(1'b1, 1'b1, 1'b0, 32'd0);
      end
      chk("wrap0", at(log2, 0), 32'hFFFF_FFF8);
      chk("wrap1", at(log2, 1), 32'hFFFF_FFFC);
      chk("wrap2", at(log2, 2), 32'h0000_0000);
      chk("stream_first", at(pop_log, 0), 32'd0);
      chk("stream_second", at(pop_log, 1), 32'd4);

      // Backpressure: 5 stalled cycles then release
      repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0);
      repeat (10) step(1'b1, 1'b1, 1'b0, 32'd0);

      // Redirect with one word buffered and one in flight, decode stalled
      step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("redir_first",  at(pop_log, 0), 32'h0000_0100);
      chk("redir_second", at(pop_log, 1), 32'h0000_0104);

      // Back-to-back redirects: last one wins
      step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0300);
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("b2b_first", at(pop_log, 0), 32'h0000_0300);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'b1, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);

      // Reset mid-stream with a fetch in flight
      repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      chk("async_valid", {31'b0, valid_out}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'd0);
      repeat (8) step(1'b1, 1'b1, 1'b0, 32'd0);
      chk("restart_first", at(pop_log, 0), RPC0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
